// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the five-stage RISC-V pipeline. Tracks
//               the EX/MEM/WB instructions as tokens and produces stage
//               enables, flushes, EX forwarding selects, a small control FSM
//               and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de_valid,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             use_rs1_de,
    input  logic             use_rs2_de,
    input  logic [4:0]       rd_de,
    input  logic             ru_we_de,
    input  logic             is_load_de,
    input  logic             is_mem_de,
    input  logic             br_taken_ex,
    input  logic             dm_ready,
    output logic             en_if,
    output logic             en_de,
    output logic             en_ex,
    output logic             flush_de,
    output logic             flush_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] c_ST_RUN       = 2'b00;
    localparam logic [1:0] c_ST_LU_BUBBLE = 2'b01;
    localparam logic [1:0] c_ST_MEM_WAIT  = 2'b10;

    localparam logic [1:0] c_FWD_RU  = 2'b00;
    localparam logic [1:0] c_FWD_MEM = 2'b01;
    localparam logic [1:0] c_FWD_WB  = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // In-flight instruction descriptor carried down the pipeline
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       mem;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } tok_t;

    tok_t             r_ex;
    tok_t             r_mem;
    tok_t             r_wb;
    tok_t             w_de_tok;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_wait;
    logic w_load_use;
    logic w_br_win;
    logic w_lu_win;
    logic w_unused;

    // Forwarding source for one EX operand; a load in MEM has no data yet
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input tok_t mem_tok,
                                           input tok_t wb_tok);
        logic [1:0] sel;
        sel = c_FWD_RU;
        if (mem_tok.valid && mem_tok.we && !mem_tok.ld &&
            (mem_tok.rd != 5'd0) && (mem_tok.rd == rs)) begin
            sel = c_FWD_MEM;
        end else if (wb_tok.valid && wb_tok.we &&
                     (wb_tok.rd != 5'd0) && (wb_tok.rd == rs)) begin
            sel = c_FWD_WB;
        end
        return sel;
    endfunction

    // Token built from the decode-stage instruction; bubbles carry no fields
    always_comb begin
        w_de_tok = '0;
        if (de_valid) begin
            w_de_tok.valid = 1'b1;
            w_de_tok.rd    = rd_de;
            w_de_tok.we    = ru_we_de;
            w_de_tok.ld    = is_load_de;
            w_de_tok.mem   = is_mem_de;
            w_de_tok.rs1   = rs1_de;
            w_de_tok.rs2   = rs2_de;
        end
    end

    // Hazard conditions and which one wins this cycle
    always_comb begin
        w_mem_wait = r_mem.valid && r_mem.mem && !dm_ready;
        w_load_use = de_valid && r_ex.valid && r_ex.ld && (r_ex.rd != 5'd0) &&
                     ((use_rs1_de && (rs1_de == r_ex.rd)) ||
                      (use_rs2_de && (rs2_de == r_ex.rd)));
        w_br_win   = br_taken_ex && !w_mem_wait;
        w_lu_win   = w_load_use && !w_mem_wait && !br_taken_ex;
    end

    // Stage enables and flushes; held at run values while in reset
    always_comb begin
        en_if    = 1'b1;
        en_de    = 1'b1;
        en_ex    = 1'b1;
        flush_de = 1'b0;
        flush_ex = 1'b0;
        if (rst_n) begin
            if (w_mem_wait) begin
                en_if = 1'b0;
                en_de = 1'b0;
                en_ex = 1'b0;
            end else if (br_taken_ex) begin
                flush_de = 1'b1;
                flush_ex = 1'b1;
            end else if (w_load_use) begin
                en_if    = 1'b0;
                flush_ex = 1'b1;
            end
        end
    end

    // EX operand forwarding selects
    always_comb begin
        fwd_a_sel = fwd_sel(r_ex.rs1, r_mem, r_wb);
        fwd_b_sel = fwd_sel(r_ex.rs2, r_mem, r_wb);
    end

    // Token pipeline: shifts only when the back end is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (en_ex) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (flush_ex) begin
                r_ex <= '0;
            end else if (en_de) begin
                r_ex <= w_de_tok;
            end
        end
    end

    // Control FSM: reports the hazard being serviced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else if (w_mem_wait) begin
            r_state <= c_ST_MEM_WAIT;
        end else if (w_load_use) begin
            r_state <= c_ST_LU_BUBBLE;
        end else begin
            r_state <= c_ST_RUN;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_cnt    <= '0;
            r_mem_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lu_win && (r_lu_cnt != '1)) begin
                r_lu_cnt <= r_lu_cnt + c_CNT_ONE;
            end
            if (w_mem_wait && (r_mem_cnt != '1)) begin
                r_mem_cnt <= r_mem_cnt + c_CNT_ONE;
            end
            if (w_br_win && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    assign ctrl_state    = r_state;
    assign lu_stall_cnt  = r_lu_cnt;
    assign mem_stall_cnt = r_mem_cnt;
    assign flush_cnt     = r_flush_cnt;

    // WB token fields that nothing downstream consumes
    assign w_unused = ^{r_wb.ld, r_wb.mem, r_wb.rs1, r_wb.rs2};

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl with an
//               expectation queue popped at each sample point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [4:0] N  = 5'b11100;   // {en_if,en_de,en_ex,flush_de,flush_ex}
    localparam logic [4:0] LU = 5'b01101;
    localparam logic [4:0] MW = 5'b00000;
    localparam logic [4:0] BR = 5'b11111;
    localparam logic [1:0] RUN = 2'b00, LUB = 2'b01, MWS = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_valid, use_rs1_de, use_rs2_de, ru_we_de, is_load_de, is_mem_de;
    logic [4:0]  rs1_de, rs2_de, rd_de;
    logic        br_taken_ex, dm_ready;
    logic        en_if, en_de, en_ex, flush_de, flush_ex;
    logic [1:0]  fwd_a_sel, fwd_b_sel, ctrl_state;
    logic [15:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [4:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  st;
        bit          st_chk;
        logic [15:0] lu;
        logic [15:0] ms;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .de_valid(de_valid),
        .rs1_de(rs1_de), .rs2_de(rs2_de),
        .use_rs1_de(use_rs1_de), .use_rs2_de(use_rs2_de),
        .rd_de(rd_de), .ru_we_de(ru_we_de), .is_load_de(is_load_de),
        .is_mem_de(is_mem_de), .br_taken_ex(br_taken_ex), .dm_ready(dm_ready),
        .en_if(en_if), .en_de(en_de), .en_ex(en_ex),
        .flush_de(flush_de), .flush_ex(flush_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ctrl_state(ctrl_state),
        .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic de_set(input logic v, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic u1, input logic u2,
                          input logic we, input logic ld, input logic mem);
        de_valid = v; rd_de = rd; rs1_de = r1; rs2_de = r2;
        use_rs1_de = u1; use_rs2_de = u2; ru_we_de = we; is_load_de = ld; is_mem_de = mem;
    endtask

    task automatic nop();
        de_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        de_set(1'b1, rd, r1, r2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] r1);
        de_set(1'b1, rd, r1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic sw(input logic [4:0] r1, input logic [4:0] r2);
        de_set(1'b1, 5'd0, r1, r2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic expect_o(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [1:0] st, input bit sc,
                            input logic [15:0] lu, input logic [15:0] ms,
                            input logic [15:0] fc);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.st = st; e.st_chk = sc;
        e.lu = lu; e.ms = ms; e.fc = fc;
        q.push_back(e);
    endtask

    task automatic compare();
        exp_t       e;
        logic [4:0] ctl;
        e   = q.pop_front();
        ctl = {en_if, en_de, en_ex, flush_de, flush_ex};
        checks++;
        assert (ctl === e.ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl, e.ctl);
        end
        checks++;
        assert (fwd_a_sel === e.fa) else begin
            failures++;
            $error("FAIL %s fwd_a observed=%b expected=%b", e.tag, fwd_a_sel, e.fa);
        end
        checks++;
        assert (fwd_b_sel === e.fb) else begin
            failures++;
            $error("FAIL %s fwd_b observed=%b expected=%b", e.tag, fwd_b_sel, e.fb);
        end
        if (e.st_chk) begin
            checks++;
            assert (ctrl_state === e.st) else begin
                failures++;
                $error("FAIL %s state observed=%b expected=%b", e.tag, ctrl_state, e.st);
            end
        end
        checks++;
        assert (lu_stall_cnt === e.lu) else begin
            failures++;
            $error("FAIL %s lu_cnt observed=%0d expected=%0d", e.tag, lu_stall_cnt, e.lu);
        end
        checks++;
        assert (mem_stall_cnt === e.ms) else begin
            failures++;
            $error("FAIL %s mem_cnt observed=%0d expected=%0d", e.tag, mem_stall_cnt, e.ms);
        end
        checks++;
        assert (flush_cnt === e.fc) else begin
            failures++;
            $error("FAIL %s flush_cnt observed=%0d expected=%0d", e.tag, flush_cnt, e.fc);
        end
    endtask

    // One pipeline cycle: inputs already driven just after the rising edge
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; br_taken_ex = 1'b1; dm_ready = 1'b1; nop();
        expect_o("rst_hold",   N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();

        // Back-to-back and one-gap ALU forwarding
        rst_n = 1'b1; br_taken_ex = 1'b0;
        alu(5, 1, 2);   expect_o("alu1",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(6, 5, 1);   expect_o("alu2",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        nop();          expect_o("fwd_mem",    N,  2'b01, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(9, 3, 4);   expect_o("gap1",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(10, 3, 4);  expect_o("gap2",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(11, 9, 3);  expect_o("gap3",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        nop();          expect_o("fwd_wb",     N,  2'b10, 2'b00, RUN, 1, 0, 0, 0); step();

        // Load-use bubble
        lw(7, 2);       expect_o("lw7",        N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(8, 7, 7);   expect_o("lu_bubble",  LU, 2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(8, 7, 7);   expect_o("lu_state",   N,  2'b00, 2'b00, LUB, 1, 1, 0, 0); step();
        nop();          expect_o("lu_fwd",     N,  2'b10, 2'b10, RUN, 1, 1, 0, 0); step();

        // Store waits three cycles in MEM
        sw(2, 3);       expect_o("sw",         N,  2'b00, 2'b00, RUN, 1, 1, 0, 0); step();
        nop(); dm_ready = 1'b0;
                        expect_o("no_mem_yet", N,  2'b00, 2'b00, RUN, 1, 1, 0, 0); step();
        alu(12, 8, 1);  expect_o("mw1",        MW, 2'b00, 2'b00, RUN, 1, 1, 0, 0); step();
                        expect_o("mw2",        MW, 2'b00, 2'b00, MWS, 1, 1, 1, 0); step();
                        expect_o("mw3",        MW, 2'b00, 2'b00, MWS, 1, 1, 2, 0); step();
        dm_ready = 1'b1;
                        expect_o("mw_done",    N,  2'b00, 2'b00, MWS, 1, 1, 3, 0); step();
        alu(13, 12, 0); expect_o("mw_after",   N,  2'b00, 2'b00, RUN, 1, 1, 3, 0); step();
        nop();          expect_o("mw_resume",  N,  2'b01, 2'b00, RUN, 1, 1, 3, 0); step();

        // Taken branch squashes DE
        alu(14, 1, 2);  expect_o("pre_br",     N,  2'b00, 2'b00, RUN, 1, 1, 3, 0); step();
        alu(15, 14, 1); br_taken_ex = 1'b1;
                        expect_o("br",         BR, 2'b00, 2'b00, RUN, 1, 1, 3, 0); step();
        nop(); br_taken_ex = 1'b0;
                        expect_o("br_ex_inv",  N,  2'b00, 2'b00, RUN, 1, 1, 3, 1); step();

        // Branch held across a load's memory wait
        lw(16, 1);      expect_o("lw16",       N,  2'b00, 2'b00, RUN, 1, 1, 3, 1); step();
        alu(17, 3, 4);  expect_o("alu17",      N,  2'b00, 2'b00, RUN, 1, 1, 3, 1); step();
        alu(18, 3, 4); br_taken_ex = 1'b1; dm_ready = 1'b0;
                        expect_o("brmw1",      MW, 2'b00, 2'b00, RUN, 1, 1, 3, 1); step();
                        expect_o("brmw2",      MW, 2'b00, 2'b00, MWS, 1, 1, 4, 1); step();
        dm_ready = 1'b1;
                        expect_o("brmw_flush", BR, 2'b00, 2'b00, MWS, 1, 1, 5, 1); step();
        nop(); br_taken_ex = 1'b0;
                        expect_o("brmw_after", N,  2'b00, 2'b00, RUN, 1, 1, 5, 2); step();

        // Branch and load-use together: branch wins, bubble not counted
        lw(19, 1);      expect_o("lw19",       N,  2'b00, 2'b00, RUN, 1, 1, 5, 2); step();
        alu(20, 19, 0); br_taken_ex = 1'b1;
                        expect_o("br_lu",      BR, 2'b00, 2'b00, RUN, 1, 1, 5, 2); step();
        nop(); br_taken_ex = 1'b0;
                        expect_o("br_lu_cnt",  N,  2'b00, 2'b00, RUN, 0, 1, 5, 3); step();

        // x0 is never a producer
        lw(0, 1);       expect_o("lw_x0",      N,  2'b00, 2'b00, RUN, 1, 1, 5, 3); step();
        alu(1, 0, 0);   expect_o("rd0_nolu",   N,  2'b00, 2'b00, RUN, 1, 1, 5, 3); step();
        alu(2, 0, 0);   expect_o("rd0_mem",    N,  2'b00, 2'b00, RUN, 1, 1, 5, 3); step();
        sw(3, 4);       expect_o("rd0_wb",     N,  2'b00, 2'b00, RUN, 1, 1, 5, 3); step();

        // Asynchronous reset while waiting on memory
        nop();          expect_o("sw2",        N,  2'b00, 2'b00, RUN, 1, 1, 5, 3); step();
        dm_ready = 1'b0;
                        expect_o("rmw1",       MW, 2'b00, 2'b00, RUN, 1, 1, 5, 3); step();
                        expect_o("rmw2",       MW, 2'b00, 2'b00, MWS, 1, 1, 6, 3); step();
        rst_n = 1'b0;
        expect_o("rst_async", N, 2'b00, 2'b00, RUN, 1, 0, 0, 0);
        #1 compare();
        @(posedge clk); #1;
        rst_n = 1'b1;
                        expect_o("post_rst",   N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        dm_ready = 1'b1;

        // MEM beats WB; a load in MEM never forwards
        alu(21, 1, 2);  expect_o("p21a",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(21, 3, 4);  expect_o("p21b",       N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        alu(22, 21, 21);expect_o("p22",        N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        lw(23, 1);      expect_o("fwd_prio",   N,  2'b01, 2'b01, RUN, 1, 0, 0, 0); step();
        de_set(1'b1, 5'd24, 5'd23, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                        expect_o("no_use",     N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();
        nop();          expect_o("no_ld_fwd",  N,  2'b00, 2'b00, RUN, 1, 0, 0, 0); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It tracks the destination and source registers of every in-flight instruction in EX, MEM and WB, and generates the stage enables and flushes (`en_de` drives the decode stage `enable`). It also generates the EX-stage forwarding selects. It resolves load-use hazards with a one-cycle bubble, freezes the whole pipeline while data memory is busy, and squashes wrong-path instructions on a taken branch.

## Interface
- CNT_W, 16, width of the saturating stall/flush event counters

- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- de_valid  in  1  DE holds a real instruction
- rs1_de, rs2_de  in  5 each  source registers of the DE instruction
- use_rs1_de, use_rs2_de  in  1 each  DE instruction reads rs1 / rs2
- rd_de  in  5  destination register of the DE instruction
- ru_we_de  in  1  DE instruction writes the register file
- is_load_de  in  1  DE instruction is a load
- is_mem_de  in  1  DE instruction is a load or store
- br_taken_ex  in  1  EX resolved a taken branch or jump
- dm_ready  in  1  data memory completes the MEM access this cycle
- en_if  out  1  enable for the PC and the IF/DE register
- en_de  out  1  enable for the DE/EX register
- en_ex  out  1  enable for the EX/MEM and MEM/WB registers
- flush_de  out  1  clear the IF/DE register to a NOP
- flush_ex  out  1  load a bubble into the DE/EX register
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 RU, 01 MEM result, 10 WB data
- ctrl_state  out  2  00 RUN, 01 LU_BUBBLE, 10 MEM_WAIT
- lu_stall_cnt, mem_stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- **Tokens.** Internal tokens EX, MEM and WB each hold {valid, rd, we, ld, mem, rs1, rs2}.
- **Advance.** When `en_ex` is 1, tokens shift: WB←MEM, MEM←EX.
  - EX←DE token when `en_de` and not `flush_ex`.
  - EX←invalid when `flush_ex`.
  - EX unchanged otherwise.
- **Zero register.** A token with rd=0 never counts as a producer.
- **Combinational conditions.**
  - mem_wait = MEM.valid & MEM.mem & !dm_ready.
  - load_use = de_valid & EX.valid & EX.ld & EX.rd≠0 & ((use_rs1_de & rs1_de==EX.rd) | (use_rs2_de & rs2_de==EX.rd)).
- **Priority:** mem_wait > br_taken_ex > load_use > normal.
  - mem_wait: all enables 0, no flushes, no tokens move.
  - br_taken_ex: all enables 1, flush_de=1, flush_ex=1 (squash IF and DE).
  - load_use: en_if=0, en_de=1, flush_ex=1, en_ex=1; flush_de=0.
  - normal: all enables 1, no flushes.
- **Forwarding** (operand A from EX.rs1, B from EX.rs2):
  - Select 01 if MEM.valid & MEM.we & !MEM.ld & MEM.rd≠0 & MEM.rd==EX.rsX.
  - Otherwise 10 if WB.valid & WB.we & WB.rd≠0 & WB.rd==EX.rsX.
  - Otherwise 00.
  - MEM wins over WB. A load in MEM never forwards from MEM.
- **FSM, evaluated each clock.**
  - Next state is MEM_WAIT if mem_wait.
  - Otherwise LU_BUBBLE if load_use.
  - Otherwise RUN.
- **Counters.** Each saturates at all-ones.
  - lu_stall_cnt +1 per cycle where load_use is the winning condition.
  - mem_stall_cnt +1 per mem_wait cycle.
  - flush_cnt +1 per winning br_taken_ex cycle.

## Timing
- **Reset values:** tokens invalid with all fields 0; ctrl_state=RUN; counters 0; fwd selects 00.
- **Outputs during reset:** enables 1, flushes 0.
- **Output timing:** enables, flushes and fwd selects are combinational from the current tokens and inputs; tokens, state and counters are registered.
- **Load-use:** exactly one bubble. The next cycle the load is in MEM and the consumer is still in DE, so no hazard remains. One cycle later the consumer is in EX with the load in WB, giving fwd=10.
- **Memory wait:** lasts until the first cycle with dm_ready=1. The pipeline advances on that edge.
- **Branch during mem_wait:** br_taken_ex stays asserted because EX is frozen. The flush takes effect in the first non-waiting cycle.
- **Branch and load-use in the same cycle:** branch wins; the load-use bubble is not counted.
- **Reset mid-stall:** all in-flight tokens are dropped and the state returns to RUN asynchronously.

## Test plan
- **Back-to-back ALU forwarding.** Apply `add x5` then `sub x6,x5,x1` with dm_ready=1 → the sub in EX gives fwd_a_sel=01. Insert one unrelated instruction between them instead → fwd_a_sel=10.
- **Load-use.** Apply `lw x7` then `add x8,x7,x7` → exactly one cycle with en_if=0, flush_ex=1, ctrl_state=01 and lu_stall_cnt=1. Then the add sees fwd_a_sel=fwd_b_sel=10.
- **Memory wait.** Put a `sw` in MEM and hold dm_ready=0 for 3 cycles → all enables 0 for 3 cycles, ctrl_state=10 and mem_stall_cnt=3. Progress resumes on the edge where dm_ready=1.
- **Taken branch.** Assert br_taken_ex for 1 cycle → flush_de=1, flush_ex=1, flush_cnt=1, and the EX token is invalid next cycle.
- **Branch held during memory wait.** Assert br_taken_ex while dm_ready=0 for 2 cycles → no flush during the wait, then flush on the first dm_ready=1 cycle.
- **rd=0 and reset.** Run `lw x0` then `add x1,x0,x0` → no stall and fwd=00. Deassert rst_n mid-MEM_WAIT → state RUN, counters 0 and tokens invalid immediately.
